// File: rtl/gamepad_poller.sv
// Serial (S)NES pad poller: shared latch/clock, one data line per pad, results held under valid/ready.
// Define GAMEPAD_PRESENCE_EN to clock one extra bit per frame and report which pads are connected.
module gamepad_poller #(
  parameter int N_PADS = 4,
  parameter int N_BITS = 16,
  parameter int N_DIV  = 42000,
  parameter int INVERT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     gp_clk,
  output logic                     gp_latch,
  input  logic [N_PADS-1:0]        gp_d,
  input  logic                     auto_en,
  input  logic                     poll_req,
  output logic [N_PADS*N_BITS-1:0] buttons,
  output logic [N_PADS-1:0]        changed,
  output logic [N_PADS-1:0]        present,
  output logic                     valid,
  input  logic                     ready,
  output logic                     busy,
  output logic                     overrun
);

`ifdef GAMEPAD_PRESENCE_EN
  localparam int PRES = 1;
`else
  localparam int PRES = 0;
`endif
  localparam int SW = N_BITS + PRES;
  localparam int CW = $clog2(SW);
  localparam int DW = (N_DIV > 2) ? $clog2(N_DIV) : 1;
  localparam logic [CW-1:0] LAST_C     = CW'(SW - 1);
  localparam logic [DW-1:0] DIV_RELOAD = DW'(N_DIV - 1);

  typedef enum logic [2:0] {IDLE, LATCH, SAMPLE, CLOCK, DONE} state_t;

  state_t                         state_q;
  logic [DW-1:0]                  div_q;
  logic [CW-1:0]                  cnt_q;
  logic                           pending_q;
  logic                           gp_clk_q;
  logic                           gp_latch_q;
  logic [N_PADS-1:0][SW-1:0]      shreg_q;
  logic [N_PADS*N_BITS-1:0]       buttons_q;
  logic [N_PADS-1:0]              changed_q;
  logic                           valid_q;
  logic                           overrun_q;

  logic                           tick;
  logic                           start;
  logic                           pending_d;
  logic [N_PADS*N_BITS-1:0]       words_d;
  logic [N_PADS-1:0]              chg_d;

  assign tick      = (div_q == '0);
  assign start     = tick && (state_q == IDLE) && (auto_en || pending_q || poll_req);
  // A request seen on the start cycle is consumed by that frame.
  assign pending_d = start ? 1'b0 : (pending_q || poll_req);

`ifdef GAMEPAD_PRESENCE_EN
  logic [N_PADS-1:0] pres_d;
  logic [N_PADS-1:0] present_q;
`endif

  always_comb begin
    words_d = '0;
    chg_d   = '0;
`ifdef GAMEPAD_PRESENCE_EN
    pres_d  = '0;
`endif
    for (int i = 0; i < N_PADS; i++) begin
      words_d[i*N_BITS +: N_BITS] = (INVERT != 0) ? ~shreg_q[i][N_BITS-1:0]
                                                  : shreg_q[i][N_BITS-1:0];
`ifdef GAMEPAD_PRESENCE_EN
      // A connected pad drives low after its last button bit; an open line is pulled high.
      pres_d[i] = ~shreg_q[i][N_BITS];
      if (!pres_d[i]) words_d[i*N_BITS +: N_BITS] = '0;
`endif
      chg_d[i] = (words_d[i*N_BITS +: N_BITS] != buttons_q[i*N_BITS +: N_BITS]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= DIV_RELOAD;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      gp_clk_q   <= 1'b0;
      gp_latch_q <= 1'b0;
      shreg_q    <= '0;
      buttons_q  <= '0;
      changed_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef GAMEPAD_PRESENCE_EN
      present_q  <= '0;
`endif
    end else begin
      div_q     <= tick ? DIV_RELOAD : div_q - DW'(1);
      pending_q <= pending_d;
      if (valid_q && ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            gp_latch_q <= 1'b1;
            shreg_q    <= '0;
            cnt_q      <= '0;
            state_q    <= LATCH;
          end
        end
        LATCH: begin
          if (tick) begin
            gp_latch_q <= 1'b0;
            state_q    <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (tick) begin
            for (int i = 0; i < N_PADS; i++) begin
              shreg_q[i] <= {gp_d[i], shreg_q[i][SW-1:1]};
            end
            gp_clk_q <= 1'b1;
            state_q  <= CLOCK;
          end
        end
        CLOCK: begin
          if (tick) begin
            gp_clk_q <= 1'b0;
            if (cnt_q == LAST_C) begin
              state_q <= DONE;
            end else begin
              cnt_q   <= cnt_q + CW'(1);
              state_q <= SAMPLE;
            end
          end
        end
        DONE: begin
          buttons_q <= words_d;
          changed_q <= chg_d;
`ifdef GAMEPAD_PRESENCE_EN
          present_q <= pres_d;
`endif
          valid_q   <= 1'b1;
          // Overwriting an unaccepted result is flagged; a same-cycle accept is not an overrun.
          if (valid_q && !ready) overrun_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gp_clk   = gp_clk_q;
  assign gp_latch = gp_latch_q;
  assign buttons  = buttons_q;
  assign changed  = changed_q;
  assign valid    = valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != IDLE);
`ifdef GAMEPAD_PRESENCE_EN
  assign present  = present_q;
`else
  assign present  = '1;
`endif

endmodule

// File: tb/tb_gamepad_poller.sv
// Directed bench for gamepad_poller with two modelled pads (N_BITS=16, N_DIV=4, INVERT=1).
module tb_gamepad_poller;
  localparam int NP = 2;
  localparam int NB = 16;
  localparam int ND = 4;
`ifdef GAMEPAD_PRESENCE_EN
  localparam int       EXP_PULSES = 17;
  localparam logic [1:0] PRES_RST = 2'b00;
`else
  localparam int       EXP_PULSES = 16;
  localparam logic [1:0] PRES_RST = 2'b11;
`endif
  localparam int FRAME_CYC = (2 * EXP_PULSES + 2) * ND;

  logic            clk = 1'b0;
  logic            rst;
  logic            gp_clk, gp_latch;
  logic [NP-1:0]   gp_d;
  logic            auto_en, poll_req, ready;
  logic [NP*NB-1:0] buttons;
  logic [NP-1:0]   changed, present;
  logic            valid, busy, overrun;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] pad_word0 = 16'hFFFE;
  logic [15:0] pad_word1 = 16'hFFFF;
  logic [1:0]  pad_conn  = 2'b11;
  logic [15:0] sr0 = 16'hFFFF;
  logic [15:0] sr1 = 16'hFFFF;

  gamepad_poller #(.N_PADS(NP), .N_BITS(NB), .N_DIV(ND), .INVERT(1)) dut (
    .clk(clk), .rst(rst), .gp_clk(gp_clk), .gp_latch(gp_latch), .gp_d(gp_d),
    .auto_en(auto_en), .poll_req(poll_req), .buttons(buttons), .changed(changed),
    .present(present), .valid(valid), .ready(ready), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, shift on each rising pad clock, low after the last bit.
  always @(posedge gp_latch or posedge gp_clk) begin
    if (gp_latch) begin
      sr0 <= pad_word0;
      sr1 <= pad_word1;
    end else begin
      sr0 <= {1'b0, sr0[15:1]};
      sr1 <= {1'b0, sr1[15:1]};
    end
  end
  assign gp_d = {pad_conn[1] ? sr1[0] : 1'b1, pad_conn[0] ? sr0[0] : 1'b1};

  task automatic run_frame(output int lat_n, output int clk_n, output int bad_w, output int to);
    int   hi;
    logic lat_prev, clk_prev, seen_busy;
    lat_n = 0; clk_n = 0; bad_w = 0; to = 1; hi = 0;
    lat_prev = 1'b0; clk_prev = 1'b0; seen_busy = 1'b0;
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (gp_latch && !lat_prev) lat_n++;
      if (gp_clk) begin
        hi++;
        if (!clk_prev) clk_n++;
      end else if (clk_prev) begin
        if (hi != ND) bad_w++;
        hi = 0;
      end
      lat_prev = gp_latch;
      clk_prev = gp_clk;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; auto_en = 1'b0; poll_req = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_vec++; if (gp_clk !== 1'b0)  begin n_err++; $display("FAIL rst_gp_clk got %b want 0", gp_clk); end
    n_vec++; if (gp_latch !== 1'b0) begin n_err++; $display("FAIL rst_gp_latch got %b want 0", gp_latch); end
    n_vec++; if (valid !== 1'b0)   begin n_err++; $display("FAIL rst_valid got %b want 0", valid); end
    n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got %b want 0", overrun); end
    n_vec++; if (changed !== 2'b00) begin n_err++; $display("FAIL rst_changed got %b want 00", changed); end
    n_vec++; if (buttons !== 32'h0) begin n_err++; $display("FAIL rst_buttons got %h want 0", buttons); end
    n_vec++; if (present !== PRES_RST) begin n_err++; $display("FAIL rst_present got %b want %b", present, PRES_RST); end
  endtask

  task automatic test_single_poll();
    int lat_n, clk_n, bad_w, to;
    run_frame(lat_n, clk_n, bad_w, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL poll_timeout got %0d want 0", to); end
    n_vec++; if (lat_n !== 1) begin n_err++; $display("FAIL poll_latch_pulses got %0d want 1", lat_n); end
    n_vec++; if (clk_n !== EXP_PULSES) begin n_err++; $display("FAIL poll_clk_pulses got %0d want %0d", clk_n, EXP_PULSES); end
    n_vec++; if (bad_w !== 0) begin n_err++; $display("FAIL poll_clk_width bad pulses %0d want 0", bad_w); end
    n_vec++; if (buttons !== 32'h0000_0001) begin n_err++; $display("FAIL poll_buttons got %h want 00000001", buttons); end
    n_vec++; if (changed !== 2'b01) begin n_err++; $display("FAIL poll_changed got %b want 01", changed); end
    repeat (10) @(negedge clk);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL poll_valid_hold got %b want 1", valid); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL poll_valid_clear got %b want 0", valid); end
  endtask

  task automatic test_repeat();
    int lat_n, clk_n, bad_w, to;
    run_frame(lat_n, clk_n, bad_w, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL repeat_timeout got %0d want 0", to); end
    n_vec++; if (buttons !== 32'h0000_0001) begin n_err++; $display("FAIL repeat_buttons got %h want 00000001", buttons); end
    n_vec++; if (changed !== 2'b00) begin n_err++; $display("FAIL repeat_changed got %b want 00", changed); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int   t_prev, n_rise;
    int   intv [2];
    logic lat_prev;
    intv[0] = 0; intv[1] = 0; t_prev = 0; n_rise = 0; lat_prev = 1'b0;
    ready = 1'b1; auto_en = 1'b1;
    for (int c = 0; c < 600 && n_rise < 3; c++) begin
      @(negedge clk);
      if (gp_latch && !lat_prev) begin
        if (n_rise > 0) intv[n_rise-1] = c - t_prev;
        t_prev = c;
        n_rise++;
      end
      lat_prev = gp_latch;
    end
    auto_en = 1'b0;
    n_vec++; if (n_rise !== 3) begin n_err++; $display("FAIL b2b_frames got %0d want 3", n_rise); end
    n_vec++; if (intv[0] !== FRAME_CYC) begin n_err++; $display("FAIL b2b_gap0 got %0d want %0d", intv[0], FRAME_CYC); end
    n_vec++; if (intv[1] !== FRAME_CYC) begin n_err++; $display("FAIL b2b_gap1 got %0d want %0d", intv[1], FRAME_CYC); end
    for (int c = 0; c < 400 && busy; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_overrun();
    int   falls;
    logic prev_busy, v1, o1;
    falls = 0; v1 = 1'b0; o1 = 1'b1;
    ready = 1'b0; auto_en = 1'b1; prev_busy = busy;
    for (int c = 0; c < 800 && falls < 2; c++) begin
      @(negedge clk);
      if (prev_busy && !busy) begin
        falls++;
        if (falls == 1) begin v1 = valid; o1 = overrun; end
      end
      prev_busy = busy;
    end
    auto_en = 1'b0;
    n_vec++; if (falls !== 2) begin n_err++; $display("FAIL ovr_frames got %0d want 2", falls); end
    n_vec++; if (v1 !== 1'b1) begin n_err++; $display("FAIL ovr_first_valid got %b want 1", v1); end
    n_vec++; if (o1 !== 1'b0) begin n_err++; $display("FAIL ovr_first_overrun got %b want 0", o1); end
    n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got %b want 1", overrun); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_valid_clear got %b want 0", valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b want 0", overrun); end
  endtask

  task automatic test_ready_on_done();
    int   lat_n, clk_n, bad_w, to, falls;
    logic clk_prev;
    run_frame(lat_n, clk_n, bad_w, to);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL rod_pre_valid got %b want 1", valid); end
    pad_word0 = 16'h5AFE;
    pad_word1 = 16'h0F0F;
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    falls = 0; clk_prev = 1'b0;
    for (int c = 0; c < 400 && falls < EXP_PULSES; c++) begin
      @(negedge clk);
      if (clk_prev && !gp_clk) falls++;
      clk_prev = gp_clk;
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    n_vec++; if (falls !== EXP_PULSES) begin n_err++; $display("FAIL rod_pulses got %0d want %0d", falls, EXP_PULSES); end
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL rod_valid got %b want 1", valid); end
    n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rod_overrun got %b want 0", overrun); end
    n_vec++; if (buttons !== 32'hF0F0_A501) begin n_err++; $display("FAIL rod_buttons got %h want f0f0a501", buttons); end
    n_vec++; if (changed !== 2'b11) begin n_err++; $display("FAIL rod_changed got %b want 11", changed); end
    repeat (2) @(negedge clk);
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL rod_valid_hold got %b want 1", valid); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int   lat_n, clk_n, bad_w, to, rises;
    logic clk_prev;
    pad_word0 = 16'hFFFE;
    pad_word1 = 16'hFFFF;
    poll_req = 1'b1;
    @(negedge clk);
    poll_req = 1'b0;
    rises = 0; clk_prev = 1'b0;
    for (int c = 0; c < 400 && rises < 8; c++) begin
      @(negedge clk);
      if (gp_clk && !clk_prev) rises++;
      clk_prev = gp_clk;
    end
    n_vec++; if (gp_clk !== 1'b1) begin n_err++; $display("FAIL mid_bit7_high got %b want 1", gp_clk); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (gp_clk !== 1'b0) begin n_err++; $display("FAIL mid_gp_clk got %b want 0", gp_clk); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %b want 0", busy); end
    n_vec++; if (gp_latch !== 1'b0) begin n_err++; $display("FAIL mid_gp_latch got %b want 0", gp_latch); end
    run_frame(lat_n, clk_n, bad_w, to);
    n_vec++; if (to !== 0) begin n_err++; $display("FAIL mid_timeout got %0d want 0", to); end
    n_vec++; if (clk_n !== EXP_PULSES) begin n_err++; $display("FAIL mid_clk_pulses got %0d want %0d", clk_n, EXP_PULSES); end
    n_vec++; if (buttons !== 32'h0000_0001) begin n_err++; $display("FAIL mid_buttons got %h want 00000001", buttons); end
    n_vec++; if (changed !== 2'b01) begin n_err++; $display("FAIL mid_changed got %b want 01", changed); end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

`ifdef GAMEPAD_PRESENCE_EN
  task automatic test_presence();
    int lat_n, clk_n, bad_w, to;
    pad_conn = 2'b01;
    run_frame(lat_n, clk_n, bad_w, to);
    n_vec++; if (clk_n !== 17) begin n_err++; $display("FAIL pres_clk_pulses got %0d want 17", clk_n); end
    n_vec++; if (present !== 2'b01) begin n_err++; $display("FAIL pres_present got %b want 01", present); end
    n_vec++; if (buttons !== 32'h0000_0001) begin n_err++; $display("FAIL pres_buttons got %h want 00000001", buttons); end
    pad_conn = 2'b11;
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_poll();
    test_repeat();
    test_back_to_back();
    test_overrun();
    test_ready_on_done();
    test_reset_mid_frame();
`ifdef GAMEPAD_PRESENCE_EN
    test_presence();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gamepad_poller.md
# gamepad_poller

Parametrised (S)NES-style serial gamepad poller for N pads sharing one latch and one clock line. Generates the latch/clock waveform from a `clk` divider and shifts in one data line per pad. Publishes all button words at once through a valid/ready handshake, with per-pad change flags and overrun detection. Supports free-running auto-poll or on-demand polling. Sits between the gamepad PMOD pads and game/CPU logic.

## Interface
- `N_PADS`, 4: number of pads / data lines, 1..8.
- `N_BITS`, 16: bits shifted per pad per frame, 8..16 (12 for NES-extended, 16 for SNES).
- `N_DIV`, 42000: `clk` cycles per tick (half bit period), ≥2.
- `INVERT`, 1: 1 means `buttons` bit = 1 when pressed (pad line inverted); 0 means raw line level.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `gp_clk`  out  1  pad shift clock
- `gp_latch`  out  1  pad parallel-load strobe
- `gp_d`  in  N_PADS  pad serial data; bit i = pad i
- `auto_en`  in  1  1 = start a new frame on every idle tick
- `poll_req`  in  1  single-cycle request for one frame
- `buttons`  out  N_PADS*N_BITS  pad i in `[i*N_BITS +: N_BITS]`; bit 0 is the first bit shifted in
- `changed`  out  N_PADS  pad i word differs from its previous published word
- `present`  out  N_PADS  pad detected (see Configuration)
- `valid`  out  1  result available
- `ready`  in  1  consumer accepts result
- `busy`  out  1  frame in progress (state ≠ IDLE)
- `overrun`  out  1  sticky: a result was overwritten while unaccepted

## Operation
- Divider: down-counter loaded with N_DIV-1. `tick` fires for one cycle when it reaches 0, then it reloads. All pad-line transitions occur only on ticks.
- `poll_req` sets `pending`. `pending` is cleared when a frame starts. Requests made while busy merge into one pending request.
- FSM (each transition happens on a tick except DONE):
  - IDLE: if `auto_en|pending`: `gp_latch`=1, clear shift regs, bit cnt=0, go to LATCH.
  - LATCH: `gp_latch`=0, go to SAMPLE.
  - SAMPLE: shift `gp_d[i]` into MSB of shreg i (right shift), `gp_clk`=1, go to CLOCK.
  - CLOCK: `gp_clk`=0. If cnt==LAST, go to DONE; else cnt++ and go to SAMPLE. LAST = N_BITS-1, or N_BITS with presence enabled.
  - DONE (one `clk` cycle, not tick-gated): publish `buttons` = shreg (complemented if INVERT); `changed[i]` = (new word i ≠ old word i); set `valid`. Go to IDLE.
- Handshake: `valid` clears on the cycle after `valid&ready`. `buttons`, `changed` and `present` change only in DONE.
- DONE while `valid`=1 and `ready`=0: data is overwritten, `valid` stays 1, `overrun`=1.
- DONE coinciding with `valid&ready`: new data is published, `valid` stays 1, no overrun.
- `overrun` clears on an accepted handshake, unless DONE sets it in the same cycle (set wins).
- Reset, including mid-frame: on the next edge, state=IDLE, `gp_clk`=`gp_latch`=0, `pending`=0, divider reloads N_DIV-1, shift regs cleared.

## Timing
- Reset values: `gp_clk`, `gp_latch`, `valid`, `busy`, `overrun`, `changed` = 0. `buttons` = 0. `present` = all ones without the macro, 0 with it.
- The first tick occurs N_DIV cycles after `rst` deasserts.
- Frame, counted in ticks from start tick T0:
  - latch high over [T0, T0+1).
  - bit k sampled at T0+2+2k; `gp_clk` high over [T0+2+2k, T0+3+2k).
  - `valid` rises 1 cycle after the final CLOCK tick.
  - Frame time = (2·(LAST+1)+2)·N_DIV cycles.
- `poll_req` takes effect at the first tick on which state is IDLE. With `auto_en`=1, the next frame starts at the tick after DONE.
- `busy` is high from the cycle after the start tick through DONE.

## Configuration
- `GAMEPAD_PRESENCE_EN` defined:
  - One extra sample/clock pair per frame (bit index N_BITS); `buttons` excludes this bit.
  - `present[i]` = 1 if that extra bit reads 0 (a connected pad drives low after its last bit; a pulled-up open line reads 1).
  - In DONE, an absent pad publishes an all-zero word.
- Undefined: N_BITS pairs only; `present` is constant all ones.

## Test plan
Common settings: N_PADS=2, N_BITS=16, N_DIV=4, INVERT=1.
- Reset then `poll_req` pulse, pad0 lines driving 0xFFFE (bit 0 low), pad1 lines driving 0xFFFF:
  - 1 latch pulse, then 16 `gp_clk` pulses, each 4 cycles high.
  - `buttons`=0x0000_0001, `changed`=2'b01, `valid` held until `ready`.
- Repeat the identical frame → `changed`=00. `auto_en`=1 → back-to-back frames 136 cycles apart (34 ticks).
- Hold `ready`=0 across 2 auto frames → `overrun`=1 after the 2nd DONE. `ready` pulse → `valid`=0 and `overrun`=0 the next cycle.
- `ready`=1 on the DONE cycle with `valid` already 1 → `valid` stays 1, `overrun` stays 0, new data published.
- Assert `rst` during bit 7 with `gp_clk` high → next edge `gp_clk`=0, `busy`=0. The next poll sees a full 16-bit frame.
- With `GAMEPAD_PRESENCE_EN`:
  - 17 clock pulses per frame.
  - pad1 line held at 1 throughout → `present`=2'b01, pad1 word=0.
